// File: rtl/ecc_secded_pipe_if.sv
// Read-path beat bundle for the SECDED check/correct pipeline.
// The master drives read beats in and takes corrected beats out.
interface ecc_secded_pipe_if #(
  parameter int DATA_WIDTH = 60,
  parameter int TAG_WIDTH  = 8,
  localparam int R = (DATA_WIDTH <= 4)   ? 3 :
                     (DATA_WIDTH <= 11)  ? 4 :
                     (DATA_WIDTH <= 26)  ? 5 :
                     (DATA_WIDTH <= 57)  ? 6 :
                     (DATA_WIDTH <= 120) ? 7 : 8,
  localparam int PW = R + 1
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_WIDTH-1:0]    in_data;
  logic [PW-1:0]            in_parity;
  logic [TAG_WIDTH-1:0]     in_tag;
  logic                     bypass;
  logic                     inj_en;
  logic [DATA_WIDTH+PW-1:0] inj_mask;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    out_data;
  logic [TAG_WIDTH-1:0]     out_tag;
  logic                     out_sbit;
  logic                     out_dbit;
  logic [7:0]               out_pos;

  modport master (
    output in_valid, in_data, in_parity, in_tag,
    output bypass, inj_en, inj_mask, out_ready,
    input  in_ready, out_valid, out_data, out_tag,
    input  out_sbit, out_dbit, out_pos
  );

  modport slave (
    input  in_valid, in_data, in_parity, in_tag,
    input  bypass, inj_en, inj_mask, out_ready,
    output in_ready, out_valid, out_data, out_tag,
    output out_sbit, out_dbit, out_pos
  );
endinterface

// File: rtl/ecc_secded_pipe.sv
// Two-stage SECDED (extended Hamming) check/correct pipeline with
// write-side encoder, error injection, saturating counters and capture.
module ecc_secded_pipe #(
  parameter int DATA_WIDTH = 60,
  parameter int TAG_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16,
  localparam int R = (DATA_WIDTH <= 4)   ? 3 :
                     (DATA_WIDTH <= 11)  ? 4 :
                     (DATA_WIDTH <= 26)  ? 5 :
                     (DATA_WIDTH <= 57)  ? 6 :
                     (DATA_WIDTH <= 120) ? 7 : 8,
  localparam int PW = R + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_WIDTH-1:0] enc_data_i,
  output logic [PW-1:0]        enc_parity_o,
  input  logic                 cnt_clr_i,
  output logic [CNT_WIDTH-1:0] sbit_cnt_o,
  output logic [CNT_WIDTH-1:0] dbit_cnt_o,
  output logic                 ferr_vld_o,
  output logic [TAG_WIDTH-1:0] ferr_tag_o,
  output logic                 ferr_dbit_o,
  ecc_secded_pipe_if.slave     bus
);
  localparam int DW = DATA_WIDTH;
  localparam int TW = TAG_WIDTH;

  function automatic logic [DW-1:0][7:0] pos_table();
    int k;
    k = 0;
    pos_table = '0;
    for (int q = 3; q < 256; q++) begin
      if (((q & (q - 1)) != 0) && (k < DW)) begin
        pos_table[k] = 8'(q);
        k++;
      end
    end
  endfunction

  localparam logic [DW-1:0][7:0] POS = pos_table();
  localparam logic [7:0] MAXPOS = POS[DW-1];

  function automatic logic [R-1:0] syn_of(
    input logic [DW-1:0] d
  );
    syn_of = '0;
    for (int i = 0; i < DW; i++)
      if (d[i]) syn_of = syn_of ^ POS[i][R-1:0];
  endfunction

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    logic          byp;
    logic [R-1:0]  syn;
    logic          ov;
  } s1_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    logic          sbit;
    logic          dbit;
    logic [7:0]    pos;
  } s2_t;

  logic [R-1:0] enc_syn;
  assign enc_syn = syn_of(enc_data_i);
  assign enc_parity_o = {^enc_data_i ^ ^enc_syn, enc_syn};

  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  logic s1_vld_q, s2_vld_q;
  logic s1_adv, in_rdy, fire;

  assign s1_adv = !s2_vld_q | bus.out_ready;
  assign in_rdy = !s1_vld_q | s1_adv;
  assign fire   = s2_vld_q & bus.out_ready;

  logic [DW+PW-1:0] cw;
  assign cw = {bus.in_parity, bus.in_data} ^
              (bus.inj_en ? bus.inj_mask : '0);

  always_comb begin
    s1_d      = '0;
    s1_d.data = cw[DW-1:0];
    s1_d.tag  = bus.in_tag;
    s1_d.byp  = bus.bypass;
    s1_d.syn  = syn_of(cw[DW-1:0]) ^ cw[DW+R-1:DW];
    s1_d.ov   = ^cw;
  end

  logic [7:0] syn8;
  logic       pow2;
  assign syn8 = 8'(s1_q.syn);
  assign pow2 = (s1_q.syn & (s1_q.syn - R'(1))) == '0;

  always_comb begin
    s2_d      = '0;
    s2_d.data = s1_q.data;
    s2_d.tag  = s1_q.tag;
    if (!s1_q.byp) begin
      if (s1_q.ov) begin
        if (pow2) begin
          s2_d.sbit = 1'b1;
          s2_d.pos  = syn8;
        end else if (syn8 > MAXPOS) begin
          s2_d.dbit = 1'b1;
        end else begin
          s2_d.sbit = 1'b1;
          s2_d.pos  = syn8;
          for (int i = 0; i < DW; i++)
            if (POS[i] == syn8) s2_d.data[i] = ~s1_q.data[i];
        end
      end else if (s1_q.syn != '0) begin
        s2_d.dbit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_q     <= '0;
      s2_vld_q <= 1'b0;
      s2_q     <= '0;
    end else begin
      if (in_rdy) begin
        s1_vld_q <= bus.in_valid;
        if (bus.in_valid) s1_q <= s1_d;
      end
      if (s1_adv) begin
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) s2_q <= s2_d;
      end
    end
  end

  logic [CNT_WIDTH-1:0] sbit_cnt_d, sbit_cnt_q;
  logic [CNT_WIDTH-1:0] dbit_cnt_d, dbit_cnt_q;
  logic                 ferr_vld_d, ferr_vld_q;
  logic [TW-1:0]        ferr_tag_d, ferr_tag_q;
  logic                 ferr_dbit_d, ferr_dbit_q;

  // Clear dominates any increment landing in the same cycle.
  always_comb begin
    sbit_cnt_d  = sbit_cnt_q;
    dbit_cnt_d  = dbit_cnt_q;
    ferr_vld_d  = ferr_vld_q;
    ferr_tag_d  = ferr_tag_q;
    ferr_dbit_d = ferr_dbit_q;
    if (cnt_clr_i) begin
      sbit_cnt_d  = '0;
      dbit_cnt_d  = '0;
      ferr_vld_d  = 1'b0;
      ferr_tag_d  = '0;
      ferr_dbit_d = 1'b0;
    end else if (fire) begin
      if (s2_q.sbit && !(&sbit_cnt_q))
        sbit_cnt_d = sbit_cnt_q + CNT_WIDTH'(1);
      if (s2_q.dbit && !(&dbit_cnt_q))
        dbit_cnt_d = dbit_cnt_q + CNT_WIDTH'(1);
      if ((s2_q.sbit | s2_q.dbit) && !ferr_vld_q) begin
        ferr_vld_d  = 1'b1;
        ferr_tag_d  = s2_q.tag;
        ferr_dbit_d = s2_q.dbit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sbit_cnt_q  <= '0;
      dbit_cnt_q  <= '0;
      ferr_vld_q  <= 1'b0;
      ferr_tag_q  <= '0;
      ferr_dbit_q <= 1'b0;
    end else begin
      sbit_cnt_q  <= sbit_cnt_d;
      dbit_cnt_q  <= dbit_cnt_d;
      ferr_vld_q  <= ferr_vld_d;
      ferr_tag_q  <= ferr_tag_d;
      ferr_dbit_q <= ferr_dbit_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = s2_vld_q;
  assign bus.out_data  = s2_q.data;
  assign bus.out_tag   = s2_q.tag;
  assign bus.out_sbit  = s2_q.sbit;
  assign bus.out_dbit  = s2_q.dbit;
  assign bus.out_pos   = s2_q.pos;

  assign sbit_cnt_o  = sbit_cnt_q;
  assign dbit_cnt_o  = dbit_cnt_q;
  assign ferr_vld_o  = ferr_vld_q;
  assign ferr_tag_o  = ferr_tag_q;
  assign ferr_dbit_o = ferr_dbit_q;
endmodule
